// File: rtl/xacc.sv
// Reduction/accumulator unit: picks one flow-bus slot and reduces it (sum, max, min, saturating sum) per period.
// Optional XACC_INREG_EN registers the selected operand, delaying every sample, result and done by one cycle.
module xacc #(
    parameter int DATA_W    = 32,
    parameter int N_W       = 5,
    parameter int DELAY_W   = 5,
    parameter int PERIOD_W  = 10,
    parameter int ITER_W    = 10,
    parameter int DATABUS_W = 512
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          run,
    output logic                                          done,
    input  logic [2*DATABUS_W-1:0]                        flow_in,
    output logic [DATA_W-1:0]                             flow_out,
    input  logic [N_W+2+DELAY_W+PERIOD_W+ITER_W-1:0]      configdata
);

    localparam int NS   = 2*DATABUS_W/DATA_W;
    localparam int DC_W = DELAY_W + 1;
`ifdef XACC_INREG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    typedef enum logic [1:0] {IDLE, DELAY, RUN} state_t;
    state_t state, state_nxt;

    logic [N_W-1:0]      cfg_sel, sel_q;
    logic [1:0]          cfg_op, op_q;
    logic [DELAY_W-1:0]  cfg_delay;
    logic [PERIOD_W-1:0] cfg_period, plast_in, plast_q, pcnt;
    logic [ITER_W-1:0]   cfg_iter, iter_q, icnt;
    logic [DC_W-1:0]     dtgt_in, dtgt_q, dcnt;
    logic [DATA_W-1:0]   sel_word, operand, acc, sum, f_val, result;
    logic                first, last_p, last_i, no_iter, sample, finish;

    assign cfg_iter   = configdata[ITER_W-1:0];
    assign cfg_period = configdata[ITER_W +: PERIOD_W];
    assign cfg_delay  = configdata[ITER_W+PERIOD_W +: DELAY_W];
    assign cfg_op     = configdata[ITER_W+PERIOD_W+DELAY_W +: 2];
    assign cfg_sel    = configdata[ITER_W+PERIOD_W+DELAY_W+2 +: N_W];

    // The input register adds one cycle, folded into the start delay.
    assign dtgt_in  = DC_W'(cfg_delay) + DC_W'(LAT);
    assign plast_in = (cfg_period == '0) ? '0 : cfg_period - PERIOD_W'(1);

    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NS; k++) begin
            if (int'(sel_q) == k) sel_word = flow_in[(NS-k)*DATA_W-1 -: DATA_W];
        end
    end

`ifdef XACC_INREG_EN
    logic [DATA_W-1:0] operand_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) operand_q <= '0;
        else      operand_q <= sel_word;
    end
    assign operand = operand_q;
`else
    assign operand = sel_word;
`endif

    assign first   = (pcnt == '0);
    assign last_p  = (pcnt == plast_q);
    assign last_i  = (icnt == iter_q - ITER_W'(1));
    assign no_iter = (iter_q == '0);
    assign sample  = (state == RUN) && !no_iter;

    always_comb begin
        sum   = acc + operand;
        f_val = sum;
        case (op_q)
            2'b01: f_val = ($signed(acc) > $signed(operand)) ? acc : operand;
            2'b10: f_val = ($signed(acc) < $signed(operand)) ? acc : operand;
            2'b11: begin
                // Overflow only when both addends share a sign the sum lost.
                if ((acc[DATA_W-1] == operand[DATA_W-1]) && (sum[DATA_W-1] != acc[DATA_W-1]))
                    f_val = acc[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
            end
            default: f_val = sum;
        endcase
        result = first ? operand : f_val;
    end

    always_comb begin
        state_nxt = state;
        finish    = 1'b0;
        case (state)
            IDLE:  if (run) state_nxt = (dtgt_in != '0) ? DELAY : RUN;
            DELAY: if (dcnt == dtgt_q - DC_W'(1)) state_nxt = RUN;
            RUN: begin
                if (no_iter || (last_p && last_i)) begin
                    state_nxt = IDLE;
                    finish    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q    <= '0;
            op_q     <= '0;
            dtgt_q   <= '0;
            plast_q  <= '0;
            iter_q   <= '0;
            acc      <= '0;
            pcnt     <= '0;
            icnt     <= '0;
            dcnt     <= '0;
            flow_out <= '0;
            done     <= 1'b0;
        end else begin
            if ((state == IDLE) && run) begin
                sel_q   <= cfg_sel;
                op_q    <= cfg_op;
                dtgt_q  <= dtgt_in;
                plast_q <= plast_in;
                iter_q  <= cfg_iter;
                acc     <= '0;
                pcnt    <= '0;
                icnt    <= '0;
                dcnt    <= '0;
                done    <= 1'b0;
            end
            if (state == DELAY) dcnt <= dcnt + DC_W'(1);
            if (sample) begin
                acc <= result;
                if (last_p) begin
                    flow_out <= result;
                    pcnt     <= '0;
                    icnt     <= icnt + ITER_W'(1);
                end else begin
                    pcnt <= pcnt + PERIOD_W'(1);
                end
            end
            if (finish) done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_xacc.sv
// Bench for xacc: directed and random reductions compared against a per-period reference model.
module tb_xacc;

    localparam int DATA_W    = 32;
    localparam int N_W       = 5;
    localparam int DELAY_W   = 5;
    localparam int PERIOD_W  = 10;
    localparam int ITER_W    = 10;
    localparam int DATABUS_W = 512;
    localparam int NS        = 2*DATABUS_W/DATA_W;
    localparam int CFG_W     = N_W+2+DELAY_W+PERIOD_W+ITER_W;
`ifdef XACC_INREG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic                   clk, rst, run, done;
    logic [2*DATABUS_W-1:0] flow_in;
    logic [DATA_W-1:0]      flow_out;
    logic [CFG_W-1:0]       configdata;

    int n_tests, n_fail;
    logic [DATA_W-1:0] exp_fo;
    logic [DATA_W-1:0] samp_q[$];
    logic [DATA_W-1:0] exp_fo_q[$], got_fo_q[$];
    logic              exp_done_q[$], got_done_q[$];
    int                edge_q[$];

    xacc #(.DATA_W(DATA_W), .N_W(N_W), .DELAY_W(DELAY_W), .PERIOD_W(PERIOD_W),
           .ITER_W(ITER_W), .DATABUS_W(DATABUS_W)) dut (
        .clk(clk), .rst(rst), .run(run), .done(done),
        .flow_in(flow_in), .flow_out(flow_out), .configdata(configdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DATA_W-1:0] ref_f(input logic [1:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        longint s, smax, smin;
        s    = longint'($signed(a)) + longint'($signed(b));
        smax = (longint'(1) << (DATA_W-1)) - 1;
        smin = -(longint'(1) << (DATA_W-1));
        case (op)
            2'd0: return a + b;
            2'd1: return ($signed(a) >= $signed(b)) ? a : b;
            2'd2: return ($signed(a) <= $signed(b)) ? a : b;
            default: begin
                if (s > smax) s = smax;
                if (s < smin) s = smin;
                return s[DATA_W-1:0];
            end
        endcase
    endfunction

    function automatic logic [2*DATABUS_W-1:0] rand_bus(input logic [N_W-1:0] sel, input logic [DATA_W-1:0] v);
        logic [2*DATABUS_W-1:0] b;
        for (int i = 0; i < NS; i++) b[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        b[(NS-int'(sel))*DATA_W-1 -: DATA_W] = v;
        return b;
    endfunction

    task automatic fill_rand(input int count);
        for (int i = 0; i < count; i++) samp_q.push_back(DATA_W'($urandom));
    endtask

    task automatic clear_sb();
        exp_fo_q.delete(); got_fo_q.delete(); exp_done_q.delete(); got_done_q.delete(); edge_q.delete();
    endtask

    // Drives one run; busy_at<0 pulses run again on the completing edge. Records expected/observed per edge.
    task automatic run_case(input logic [N_W-1:0] sel, input logic [1:0] op, input int d, input int per,
                            input int it, input int busy_at, input int extra);
        int peff, c, busy;
        logic [DATA_W-1:0] val[];
        logic [DATA_W-1:0] pres[];
        logic [DATA_W-1:0] s;
        int pedge[];
        peff = (per == 0) ? 1 : per;
        c    = (it == 0) ? 1 + LAT + d : LAT + d + it*peff;
        busy = (busy_at < 0) ? c : busy_at;
        val  = new[c + extra + 1];
        foreach (val[i]) val[i] = DATA_W'($urandom);
        pres  = new[it];
        pedge = new[it];
        for (int p = 0; p < it; p++) begin
            for (int k = 0; k < peff; k++) begin
                s = samp_q[p*peff + k];
                val[1 + d + p*peff + k] = s;
                pres[p] = (k == 0) ? s : ref_f(op, pres[p], s);
            end
            pedge[p] = LAT + d + (p+1)*peff;
        end
        for (int n = 0; n <= c + extra; n++) begin
            flow_in    = rand_bus(sel, val[n]);
            run        = (n == 0) || (n == busy);
            configdata = (n == 0) ? {sel, op, d[DELAY_W-1:0], per[PERIOD_W-1:0], it[ITER_W-1:0]} : CFG_W'($urandom);
            @(posedge clk); #1;
            for (int p = 0; p < it; p++) if (pedge[p] == n) exp_fo = pres[p];
            exp_fo_q.push_back(exp_fo);
            exp_done_q.push_back(n >= c);
            got_fo_q.push_back(flow_out);
            got_done_q.push_back(done);
            edge_q.push_back(n);
        end
        run = 1'b0;
        samp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run = 1'(i); flow_in = rand_bus(5'(i), DATA_W'($urandom)); configdata = CFG_W'($urandom);
            @(posedge clk); #1;
            n_tests++; if (flow_out !== '0) begin n_fail++; $display("FAIL reset flow_out: got %h want 0", flow_out); end
            n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b want 0", done); end
        end
        run = 1'b0; rst = 1'b1; exp_fo = '0;
        for (int i = 0; i < 10; i++) begin
            flow_in = rand_bus(5'($urandom), DATA_W'($urandom)); configdata = CFG_W'($urandom);
            @(posedge clk); #1;
            n_tests++; if (flow_out !== '0) begin n_fail++; $display("FAIL idle flow_out: got %h want 0", flow_out); end
            n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL idle done: got %b want 0", done); end
        end
    endtask

    task automatic test_sum();
        clear_sb();
        for (int i = 1; i <= 8; i++) samp_q.push_back(DATA_W'(i));
        run_case(5'd2, 2'b00, 0, 4, 2, 0, 2);
        foreach (exp_fo_q[i]) begin
            n_tests++; if (got_fo_q[i] !== exp_fo_q[i]) begin n_fail++; $display("FAIL sum flow_out @%0d: got %h want %h", edge_q[i], got_fo_q[i], exp_fo_q[i]); end
            n_tests++; if (got_done_q[i] !== exp_done_q[i]) begin n_fail++; $display("FAIL sum done @%0d: got %b want %b", edge_q[i], got_done_q[i], exp_done_q[i]); end
        end
    endtask

    task automatic test_signed();
        clear_sb();
        samp_q = '{32'hFFFF_FFFB, 32'd3, 32'hFFFF_FFFF, 32'd2};
        run_case(5'd9, 2'b01, 0, 4, 1, 0, 1);
        samp_q = '{32'hFFFF_FFFB, 32'd3, 32'hFFFF_FFFF, 32'd2};
        run_case(5'd31, 2'b10, 1, 4, 1, 0, 1);
        foreach (exp_fo_q[i]) begin
            n_tests++; if (got_fo_q[i] !== exp_fo_q[i]) begin n_fail++; $display("FAIL signed flow_out @%0d: got %h want %h", edge_q[i], got_fo_q[i], exp_fo_q[i]); end
            n_tests++; if (got_done_q[i] !== exp_done_q[i]) begin n_fail++; $display("FAIL signed done @%0d: got %b want %b", edge_q[i], got_done_q[i], exp_done_q[i]); end
        end
    endtask

    task automatic test_saturation();
        clear_sb();
        samp_q = '{32'h7FFF_FFF0, 32'h0000_0020, 32'h8000_0010, 32'hFFFF_FF00};
        run_case(5'd0, 2'b11, 0, 2, 2, 0, 1);
        samp_q = '{32'h1000_0000, 32'h2000_0000, 32'hF000_0000};
        run_case(5'd4, 2'b11, 0, 3, 1, 0, 1);
        foreach (exp_fo_q[i]) begin
            n_tests++; if (got_fo_q[i] !== exp_fo_q[i]) begin n_fail++; $display("FAIL sadd flow_out @%0d: got %h want %h", edge_q[i], got_fo_q[i], exp_fo_q[i]); end
            n_tests++; if (got_done_q[i] !== exp_done_q[i]) begin n_fail++; $display("FAIL sadd done @%0d: got %b want %b", edge_q[i], got_done_q[i], exp_done_q[i]); end
        end
    endtask

    task automatic test_delay_busy();
        clear_sb();
        fill_rand(3);
        run_case(5'd6, 2'b00, 3, 1, 3, 2, 2);
        foreach (exp_fo_q[i]) begin
            n_tests++; if (got_fo_q[i] !== exp_fo_q[i]) begin n_fail++; $display("FAIL delay flow_out @%0d: got %h want %h", edge_q[i], got_fo_q[i], exp_fo_q[i]); end
            n_tests++; if (got_done_q[i] !== exp_done_q[i]) begin n_fail++; $display("FAIL delay done @%0d: got %b want %b", edge_q[i], got_done_q[i], exp_done_q[i]); end
        end
    endtask

    task automatic test_corners();
        clear_sb();
        run_case(5'd3, 2'b00, 2, 4, 0, 0, 2);
        run_case(5'd3, 2'b01, 0, 7, 0, 0, 1);
        fill_rand(3);
        run_case(5'd7, 2'b00, 1, 0, 3, 0, 1);
        fill_rand(4);
        run_case(5'd5, 2'b01, 0, 2, 2, -1, 0);
        fill_rand(2);
        run_case(5'd5, 2'b00, 0, 1, 2, 0, 1);
        foreach (exp_fo_q[i]) begin
            n_tests++; if (got_fo_q[i] !== exp_fo_q[i]) begin n_fail++; $display("FAIL corner flow_out @%0d: got %h want %h", edge_q[i], got_fo_q[i], exp_fo_q[i]); end
            n_tests++; if (got_done_q[i] !== exp_done_q[i]) begin n_fail++; $display("FAIL corner done @%0d: got %b want %b", edge_q[i], got_done_q[i], exp_done_q[i]); end
        end
    endtask

    task automatic test_max_fields();
        clear_sb();
        fill_rand(2*1023);
        run_case(5'd30, 2'b00, 31, 1023, 2, 0, 1);
        fill_rand(1023);
        run_case(5'd1, 2'b11, 0, 1, 1023, 0, 1);
        foreach (exp_fo_q[i]) begin
            n_tests++; if (got_fo_q[i] !== exp_fo_q[i]) begin n_fail++; $display("FAIL maxfield flow_out @%0d: got %h want %h", edge_q[i], got_fo_q[i], exp_fo_q[i]); end
            n_tests++; if (got_done_q[i] !== exp_done_q[i]) begin n_fail++; $display("FAIL maxfield done @%0d: got %b want %b", edge_q[i], got_done_q[i], exp_done_q[i]); end
        end
    endtask

    task automatic test_random();
        int per, it;
        clear_sb();
        for (int r = 0; r < 30; r++) begin
            per = $urandom_range(0, 5);
            it  = $urandom_range(0, 4);
            fill_rand(((per == 0) ? 1 : per) * it);
            run_case(5'($urandom), 2'($urandom), $urandom_range(0, 4), per, it, 0, $urandom_range(0, 2));
        end
        foreach (exp_fo_q[i]) begin
            n_tests++; if (got_fo_q[i] !== exp_fo_q[i]) begin n_fail++; $display("FAIL random flow_out @%0d: got %h want %h", edge_q[i], got_fo_q[i], exp_fo_q[i]); end
            n_tests++; if (got_done_q[i] !== exp_done_q[i]) begin n_fail++; $display("FAIL random done @%0d: got %b want %b", edge_q[i], got_done_q[i], exp_done_q[i]); end
        end
    endtask

    task automatic test_rst_midrun();
        logic [DATA_W-1:0] v;
        configdata = {5'd2, 2'b00, 5'd0, 10'd1, 10'd8};
        run = 1'b1; flow_in = rand_bus(5'd2, DATA_W'($urandom));
        @(posedge clk); #1;
        run = 1'b0; configdata = CFG_W'($urandom);
        v = '0;
        for (int i = 0; i < 3 + LAT; i++) begin
            v = DATA_W'($urandom) | 32'h1;
            flow_in = rand_bus(5'd2, v);
            @(posedge clk); #1;
        end
        n_tests++; if (flow_out !== v) begin n_fail++; $display("FAIL midrun pre-reset flow_out: got %h want %h", flow_out, v); end
        #2 rst = 1'b0;
        #1;
        n_tests++; if (flow_out !== '0) begin n_fail++; $display("FAIL midrun async flow_out: got %h want 0", flow_out); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrun async done: got %b want 0", done); end
        @(posedge clk); #1;
        rst = 1'b1; exp_fo = '0;
        @(posedge clk); #1;
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrun post-release done: got %b want 0", done); end
        clear_sb();
        samp_q = '{32'd7, 32'd8};
        run_case(5'd2, 2'b00, 0, 2, 1, 0, 2);
        foreach (exp_fo_q[i]) begin
            n_tests++; if (got_fo_q[i] !== exp_fo_q[i]) begin n_fail++; $display("FAIL rerun flow_out @%0d: got %h want %h", edge_q[i], got_fo_q[i], exp_fo_q[i]); end
            n_tests++; if (got_done_q[i] !== exp_done_q[i]) begin n_fail++; $display("FAIL rerun done @%0d: got %b want %b", edge_q[i], got_done_q[i], exp_done_q[i]); end
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; exp_fo = '0;
        rst = 1'b0; run = 1'b0; flow_in = '0; configdata = '0;
        test_reset();
        test_sum();
        test_signed();
        test_saturation();
        test_delay_busy();
        test_corners();
        test_max_fields();
        test_random();
        test_rst_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
